// File: rtl/lsu_pipe.sv
// lsu_pipe: handshaked load/store unit between the MEM and WB stages.
//
// Byte-addressed requests target a synchronous-read data memory, a bank of
// N_OUT 32-bit memory-mapped output registers, or a read-only switch port
// behind a two-flop synchroniser. Each accepted request produces exactly one
// response held in a one-entry register with backpressure.
//
// Ports:
//   i_clk, i_reset             clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready  request handshake
//   i_req_wren                 1 = store, 0 = load
//   i_req_addr                 byte address
//   i_req_wdata                store data (low byte/half used for SB/SH)
//   i_req_sl                   access type (SB SH SW LB LH LW LBU LHU = 0..7)
//   o_rsp_valid / i_rsp_ready  response handshake
//   o_rsp_rdata                extended load data, 0 for stores and errors
//   o_rsp_err                  misaligned / unmapped / type-direction error
//   o_io_out                   output registers, reg k at [32k+31:32k]
//   i_io_sw                    asynchronous switch inputs
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never waits on ready. o_req_ready depends only on the held
// response and i_rsp_ready, never on i_req_valid.
module lsu_pipe #(
  parameter int DMEM_AW = 11,
  parameter int N_OUT   = 5,
  parameter int SW_W    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wren,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  input  logic [2:0]            i_req_sl,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [32*N_OUT-1:0]   o_io_out,
  input  logic [SW_W-1:0]       i_io_sw
);

  localparam logic [2:0] SL_SB  = 3'd0;
  localparam logic [2:0] SL_SH  = 3'd1;
  localparam logic [2:0] SL_SW  = 3'd2;
  localparam logic [2:0] SL_LB  = 3'd3;
  localparam logic [2:0] SL_LH  = 3'd4;
  localparam logic [2:0] SL_LW  = 3'd5;
  localparam logic [2:0] SL_LBU = 3'd6;
  localparam logic [2:0] SL_LHU = 3'd7;

  typedef enum logic [1:0] {RGN_NONE, RGN_DMEM, RGN_OUT, RGN_SW} region_e;

  // ---------------------------------------------------------------- decode
  logic [3:0]         out_sel;
  logic               in_dmem, in_out, in_sw;
  region_e            req_region;
  logic               is_half, is_word, store_type;
  logic               misaligned, type_err, req_err;
  logic [DMEM_AW-1:0] word_idx;

  assign out_sel  = i_req_addr[15:12];
  assign word_idx = i_req_addr[DMEM_AW+1:2];
  // Upper bits all zero covers both addr[31:28]==0 and the DMEM size limit.
  assign in_dmem  = (i_req_addr >> (DMEM_AW + 2)) == 32'd0;
  assign in_out   = (i_req_addr[31:16] == 16'h1000) && ({28'd0, out_sel} < 32'(N_OUT));
  assign in_sw    = (i_req_addr[31:12] == 20'h10010);

  always_comb begin
    req_region = RGN_NONE;
    if (in_dmem)     req_region = RGN_DMEM;
    else if (in_out) req_region = RGN_OUT;
    else if (in_sw)  req_region = RGN_SW;
  end

  assign is_half    = (i_req_sl == SL_SH) || (i_req_sl == SL_LH) || (i_req_sl == SL_LHU);
  assign is_word    = (i_req_sl == SL_SW) || (i_req_sl == SL_LW);
  assign store_type = (i_req_sl <= SL_SW);
  assign misaligned = (is_half && i_req_addr[0]) || (is_word && (i_req_addr[1:0] != 2'b00));
  assign type_err   = (i_req_wren != store_type);
  assign req_err    = (req_region == RGN_NONE) || misaligned || type_err || (i_req_wren && in_sw);

  // ------------------------------------------------------------- handshake
  logic rsp_valid_q;
  logic accept, do_store, do_load;

  assign o_req_ready = !rsp_valid_q || i_rsp_ready;
  assign accept      = i_req_valid && o_req_ready;
  assign do_store    = accept && i_req_wren && !req_err;
  assign do_load     = accept && !i_req_wren && !req_err;

  // Byte enables and lane-replicated store data.
  logic [3:0]  be;
  logic [31:0] wdat;
  always_comb begin
    be   = 4'b0001 << i_req_addr[1:0];
    wdat = {4{i_req_wdata[7:0]}};
    if (is_word) begin
      be   = 4'b1111;
      wdat = i_req_wdata;
    end else if (is_half) begin
      be   = i_req_addr[1] ? 4'b1100 : 4'b0011;
      wdat = {2{i_req_wdata[15:0]}};
    end
  end

  // ------------------------------------------------------------ data memory
  logic [31:0] mem [0:(1<<DMEM_AW)-1];
  logic [31:0] dmem_q;

  // Read register only moves on an accepted DMEM load, so the raw word is
  // frozen while a response is stalled.
  always_ff @(posedge i_clk) begin
    if (do_store && in_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
    if (do_load && in_dmem) dmem_q <= mem[word_idx];
  end

  // ------------------------------------------------------ output registers
  logic [31:0] out_q [N_OUT];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else if (do_store && in_out) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (out_sel == 4'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) out_q[k][8*b +: 8] <= wdat[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    o_io_out = '0;
    for (int k = 0; k < N_OUT; k++) o_io_out[32*k +: 32] = out_q[k];
  end

  // ------------------------------------------------- switch synchroniser
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Raw word for non-DMEM loads, captured at accept alongside the response.
  logic [31:0] io_rd;
  always_comb begin
    io_rd = 32'(sw_sync_q);
    if (in_out) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (out_sel == 4'(k)) io_rd = out_q[k];
      end
    end
  end

  // ------------------------------------------------------ response register
  logic        rsp_err_q;
  logic [2:0]  rsp_sl_q;
  logic [1:0]  rsp_lo_q;
  region_e     rsp_region_q;
  logic [31:0] io_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_sl_q     <= SL_SB;
      rsp_lo_q     <= 2'b00;
      rsp_region_q <= RGN_NONE;
      io_q         <= '0;
    end else if (accept) begin
      rsp_valid_q  <= 1'b1;
      rsp_err_q    <= req_err;
      rsp_sl_q     <= i_req_sl;
      rsp_lo_q     <= i_req_addr[1:0];
      rsp_region_q <= req_region;
      if (do_load && !in_dmem) io_q <= io_rd;
    end else if (i_rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  // Lane extraction from held fields; stores fall to the default (0).
  logic [31:0] raw;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign raw = (rsp_region_q == RGN_DMEM) ? dmem_q : io_q;

  always_comb begin
    case (rsp_lo_q)
      2'd0:    sel_b = raw[7:0];
      2'd1:    sel_b = raw[15:8];
      2'd2:    sel_b = raw[23:16];
      default: sel_b = raw[31:24];
    endcase
    sel_h = rsp_lo_q[1] ? raw[31:16] : raw[15:0];
    o_rsp_rdata = '0;
    if (rsp_valid_q && !rsp_err_q) begin
      case (rsp_sl_q)
        SL_LB:   o_rsp_rdata = {{24{sel_b[7]}}, sel_b};
        SL_LBU:  o_rsp_rdata = {24'd0, sel_b};
        SL_LH:   o_rsp_rdata = {{16{sel_h[15]}}, sel_h};
        SL_LHU:  o_rsp_rdata = {16'd0, sel_h};
        SL_LW:   o_rsp_rdata = raw;
        default: o_rsp_rdata = '0;
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_valid_q && rsp_err_q;

endmodule

// File: doc/lsu_pipe.md
# lsu_pipe

Parametrised, handshaked load/store unit for the pipelined core. It replaces the combinational-read LSU with a synchronous-read data memory, byte-enable stores, and a generic bank of N memory-mapped output registers. It adds a two-flop switch synchroniser, misalignment and unmapped-address error reporting, and a one-entry response register with backpressure. It sits between the MEM stage and the WB stage.

## Interface
- DMEM_AW, 11, word-address bits of data memory (depth 2**DMEM_AW words; byte range 0 .. 4*2**DMEM_AW-1)
- N_OUT, 5, number of 32-bit output registers (1..16)
- SW_W, 32, switch input width (1..32)
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid & ready
- i_req_wren  in  1  1 = store, 0 = load
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data (low byte / half used for SB / SH)
- i_req_sl  in  3  access type: SB 000, SH 001, SW 010, LB 011, LH 100, LW 101, LBU 110, LHU 111
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when valid & ready
- o_rsp_rdata  out  32  load data, extended per type; 0 for stores and errors
- o_rsp_err  out  1  access was misaligned, unmapped, or had a type/direction mismatch
- o_io_out  out  32*N_OUT  output registers, reg k at bits [32k+31:32k]
- i_io_sw  in  SW_W  asynchronous switch inputs

## Operation
- Address map:
  - DMEM: addr[31:28] == 0 and addr < 4*2**DMEM_AW.
  - OUT k: addr[31:12] == 0x10000 + k, for k < N_OUT; the register is selected by addr[15:12] and addr[11:0] is ignored.
  - SW: addr[31:12] == 0x10010.
  - Everything else is unmapped.
- Error conditions (any one sets o_rsp_err):
  - unmapped address;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - store with a load type, or load with a store type;
  - any store to SW.
- An error access writes nothing and returns rdata 0.
- Store, no error: byte enables are derived from the type and addr[1:0]. SB writes lane addr[1:0]; SH writes lanes {addr[1], 0} and {addr[1], 1}; SW writes all four lanes. Data is replicated into the selected lanes. Unselected lanes are unchanged, with no read-modify-write.
- Load: a 32-bit word is read from the target. The selected lane is extracted and extended:
  - LB / LH sign-extend;
  - LBU / LHU zero-extend;
  - LW returns the word unchanged.
  - An SW-region read returns the synced switches zero-extended from SW_W, followed by lane extraction.
- Switch synchroniser: two flops, both reset to 0. The second stage is the readable value.
- Response register holds valid, err, the sl type, addr[1:0], the region, and the raw 32-bit read word. o_rsp_rdata is the combinational extraction from these held fields, so it is stable while stalled.
- DMEM read port updates only on an accepted load. The raw word therefore stays frozen during a stall.

## Timing
- o_req_ready = !o_rsp_valid | i_rsp_ready, computed combinationally. There is no path from i_req_valid to o_req_ready.
- Accept at edge T:
  - A store commits to DMEM or OUT at edge T.
  - o_rsp_valid is 1 after T, for loads and stores alike.
- Back-to-back accepts at full rate are allowed while i_rsp_ready = 1. A load accepted at T+1 to the address stored at T returns the new data.
- Stall: with o_rsp_valid = 1 and i_rsp_ready = 0, o_req_ready = 0. No state changes and all outputs hold.
- An accept and a response retire in the same cycle: the new response replaces the old one, and o_rsp_valid stays 1.
- Response with no accept: o_rsp_valid clears at the next edge.
- Reset (i_reset = 0, at any time including mid-stall):
  - o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0;
  - o_io_out = 0;
  - sync flops = 0;
  - o_req_ready = 1;
  - any pending response is dropped.
  - DMEM contents are not reset.
- Switch latency: a change on i_io_sw is readable by a load accepted 2 edges later.

## Test plan
- Reset mid-stall: hold a load response with i_rsp_ready = 0, then pulse i_reset = 0. Required: o_rsp_valid = 0, o_io_out = 0, o_req_ready = 1.
- SW 0x8000_00F1 to 0x0000_0010, then LB, LBU, LH, LHU, LW at 0x10, 0x10, 0x12, 0x12, 0x10. Required rdata: 0xFFFF_FFF1, 0x0000_00F1, 0xFFFF_8000, 0x0000_8000, 0x8000_00F1.
- SB 0xAB to 0x13 over the stored word 0x1122_3344 at 0x10, then LW 0x10, issued back-to-back. Required: 0xAB22_3344, with rsp_valid on consecutive cycles.
- SW 0x0000_007F to 0x1000_2000. Required: o_io_out[95:64] = 0x7F after the accept edge. LW 0x1000_2004 then returns 0x7F with err 0.
- Errors: LW 0x0000_0002, SH 0x0000_0001, LW 0x2000_0000, SW to 0x1001_0000. Each requires err = 1, rdata 0, and no state change.
- Backpressure: hold i_rsp_ready = 0 for 3 cycles. Required: o_req_ready = 0 and rdata stable throughout. After release, the next request is accepted in the same cycle.
- Switch sync: set i_io_sw = 0x5A with SW_W = 8. LW 0x1001_0000 accepted 2 edges later returns 0x5A; accepted 1 edge later it returns the old value.
